// File: rtl/hc163_chain.sv
// Synchronous presettable up/down counter built from 4-bit binary or BCD stages,
// with a cascadable ripple-carry/borrow output in the style of the 74HC163 family.
module hc163_chain #(
    parameter int WIDTH  = 4,
    parameter int DECADE = 0
) (
    input  logic             p2,
    input  logic             p1,
    input  logic             p9,
    input  logic             p7,
    input  logic             p10,
    input  logic             p5,
    input  logic [WIDTH-1:0] p_d,
    output logic [WIDTH-1:0] p_q,
    output logic             p15
);
    localparam int         STAGES = WIDTH / 4;
    localparam logic [3:0] TOP    = (DECADE != 0) ? 4'd9 : 4'd15;

    logic [WIDTH-1:0]  cnt_q;
    logic [WIDTH-1:0]  cnt_d;
    logic [STAGES-1:0] term;

    function automatic logic [3:0] step_digit(input logic [3:0] s, input logic up);
        logic [3:0] r;
        if (DECADE == 0)
            r = up ? s + 4'd1 : s - 4'd1;
        else if (s > 4'd9)
            r = up ? 4'd0 : 4'd9;  // out-of-range BCD digit recovers; term stays low, so no carry
        else if (up)
            r = (s == 4'd9) ? 4'd0 : s + 4'd1;
        else
            r = (s == 4'd0) ? 4'd9 : s - 4'd1;
        return r;
    endfunction

    // A stage is terminal when it is at the top digit (up) or at zero (down).
    always_comb begin
        term = '0;
        for (int s = 0; s < STAGES; s++)
            term[s] = p5 ? (cnt_q[4*s +: 4] == TOP) : (cnt_q[4*s +: 4] == 4'd0);
    end

    always_comb begin
        logic carry;
        carry = 1'b1;
        cnt_d = cnt_q;
        for (int s = 0; s < STAGES; s++) begin
            if (carry)
                cnt_d[4*s +: 4] = step_digit(cnt_q[4*s +: 4], p5);
            carry = carry & term[s];
        end
    end

    // NOTE: clear is sampled on the clock edge only; there is deliberately no
    // asynchronous branch, and register updates use <= so all bits change together.
    always_ff @(posedge p2) begin
        if (!p1)
            cnt_q <= '0;
        else if (!p9)
            cnt_q <= p_d;
        else if (p7 && p10)
            cnt_q <= cnt_d;
    end

    assign p_q = cnt_q;
    assign p15 = p10 & (&term);

endmodule

// File: tb/tb_hc163_chain.sv
// Scoreboarded bench: binary 8-bit, BCD 8-bit, binary 4-bit and a cascaded pair of
// 4-bit counters, all driven from shared stimulus and compared against arithmetic models.
module tb_hc163_chain;
    logic       clk;
    logic       clr_n, ld_n, enp, ent, up;
    logic [7:0] d;

    logic [7:0] q_b8, q_d8;
    logic [3:0] q_b4, q_lo, q_hi;
    logic       rco_b8, rco_d8, rco_b4, rco_lo, rco_hi;

    hc163_chain #(.WIDTH(8), .DECADE(0)) u_b8 (
        .p2(clk), .p1(clr_n), .p9(ld_n), .p7(enp), .p10(ent), .p5(up),
        .p_d(d), .p_q(q_b8), .p15(rco_b8));
    hc163_chain #(.WIDTH(8), .DECADE(1)) u_d8 (
        .p2(clk), .p1(clr_n), .p9(ld_n), .p7(enp), .p10(ent), .p5(up),
        .p_d(d), .p_q(q_d8), .p15(rco_d8));
    hc163_chain #(.WIDTH(4), .DECADE(0)) u_b4 (
        .p2(clk), .p1(clr_n), .p9(ld_n), .p7(enp), .p10(ent), .p5(up),
        .p_d(d[3:0]), .p_q(q_b4), .p15(rco_b4));
    hc163_chain #(.WIDTH(4), .DECADE(0)) u_lo (
        .p2(clk), .p1(clr_n), .p9(ld_n), .p7(enp), .p10(ent), .p5(up),
        .p_d(d[3:0]), .p_q(q_lo), .p15(rco_lo));
    hc163_chain #(.WIDTH(4), .DECADE(0)) u_hi (
        .p2(clk), .p1(clr_n), .p9(ld_n), .p7(enp), .p10(rco_lo), .p5(up),
        .p_d(d[7:4]), .p_q(q_hi), .p15(rco_hi));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       rco;
    } exp_t;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string nm[5]   = '{"bin8", "bcd8", "bin4", "casc", "casc_lo"};

    // Reference model state; the cascade is modelled as a single 8-bit binary counter.
    logic [7:0] m_b8, m_d8, m_b4, m_c;
    bit         known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] v, input int w, input bit dec, input bit u);
        logic [7:0] mask, r;
        logic [3:0] dg;
        int         n, m, nd;
        bit         valid, carry;
        mask = (w == 8) ? 8'hFF : 8'h0F;
        if (!dec)
            return (v + (u ? 8'd1 : 8'hFF)) & mask;
        nd    = w / 4;
        valid = 1'b1;
        for (int i = 0; i < nd; i++)
            if (((v >> (4 * i)) & 8'h0F) > 8'd9) valid = 1'b0;
        if (valid) begin
            n = 0;
            m = 1;
            for (int i = nd - 1; i >= 0; i--) n = n * 10 + int'((v >> (4 * i)) & 8'h0F);
            for (int i = 0; i < nd; i++) m = m * 10;
            n = u ? (n + 1) % m : (n + m - 1) % m;
            r = 8'h00;
            for (int i = 0; i < nd; i++) begin
                r = r | (8'(n % 10) << (4 * i));
                n = n / 10;
            end
            return r;
        end
        r     = v & mask;
        carry = 1'b1;
        for (int i = 0; i < nd; i++) begin
            dg = r[4*i +: 4];
            if (carry) begin
                if (dg > 4'd9) begin
                    dg    = u ? 4'd0 : 4'd9;
                    carry = 1'b0;
                end else if (u) begin
                    if (dg == 4'd9) dg = 4'd0;
                    else begin dg = dg + 4'd1; carry = 1'b0; end
                end else begin
                    if (dg == 4'd0) dg = 4'd9;
                    else begin dg = dg - 4'd1; carry = 1'b0; end
                end
                r[4*i +: 4] = dg;
            end
        end
        return r;
    endfunction

    function automatic bit tc(input logic [7:0] v, input int w, input bit dec, input bit u);
        logic [7:0] mask, top;
        mask = (w == 8) ? 8'hFF : 8'h0F;
        top  = dec ? (8'h99 & mask) : mask;
        return u ? ((v & mask) == top) : ((v & mask) == 8'h00);
    endfunction

    task automatic push(input int id, input logic [7:0] q, input logic rco);
        exp_t e;
        e.id  = id;
        e.q   = q;
        e.rco = rco;
        sb.push_back(e);
    endtask

    // Drive inputs for the next edge; expect the current model state plus the
    // carry the current inputs produce, then advance the model across that edge.
    task automatic cycle(input bit c, input bit l, input bit e_p, input bit e_t,
                         input bit u, input logic [7:0] dv);
        @(posedge clk);
        #1;
        clr_n = c; ld_n = l; enp = e_p; ent = e_t; up = u; d = dv;
        if (known) begin
            push(0, m_b8, e_t & tc(m_b8, 8, 1'b0, u));
            push(1, m_d8, e_t & tc(m_d8, 8, 1'b1, u));
            push(2, m_b4, e_t & tc(m_b4, 4, 1'b0, u));
            push(3, m_c,  e_t & tc(m_c,  8, 1'b0, u));
            push(4, {4'h0, m_c[3:0]}, e_t & tc(m_c, 4, 1'b0, u));
        end
        if (!c) begin
            m_b8 = 8'h00; m_d8 = 8'h00; m_b4 = 8'h00; m_c = 8'h00;
            known = 1'b1;
        end else if (!l) begin
            m_b8 = dv; m_d8 = dv; m_b4 = {4'h0, dv[3:0]}; m_c = dv;
            known = 1'b1;
        end else if (e_p && e_t) begin
            m_b8 = nxt(m_b8, 8, 1'b0, u);
            m_d8 = nxt(m_d8, 8, 1'b1, u);
            m_b4 = nxt(m_b4, 4, 1'b0, u);
            m_c  = nxt(m_c,  8, 1'b0, u);
        end
    endtask

    // Monitor: every falling edge, drain whatever the stimulus queued for this cycle.
    exp_t       me;
    logic [7:0] aq;
    logic       ar;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            me = sb.pop_front();
            case (me.id)
                0:       begin aq = q_b8;           ar = rco_b8; end
                1:       begin aq = q_d8;           ar = rco_d8; end
                2:       begin aq = {4'h0, q_b4};   ar = rco_b4; end
                3:       begin aq = {q_hi, q_lo};   ar = rco_hi; end
                default: begin aq = {4'h0, q_lo};   ar = rco_lo; end
            endcase
            check($sformatf("%s.q", nm[me.id]), 32'(aq), 32'(me.q));
            check($sformatf("%s.rco", nm[me.id]), 32'(ar), 32'(me.rco));
        end
    end

    bit up_r;

    initial begin
        clr_n = 1'b0; ld_n = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1; d = 8'h00;

        // Clear, then a full binary count through wrap with RCO only at 255.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i <= 256; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'(i));
            push(0, 8'(i), i == 255);
        end

        // BCD load 0x98 then count up through 0x99 wrap.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00); push(1, 8'h98, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00); push(1, 8'h99, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00); push(1, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00); push(1, 8'h01, 1'b0);

        // Out-of-range BCD digit recovery in both directions.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0C);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00); push(1, 8'h0C, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C); push(1, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00); push(1, 8'h0C, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); push(1, 8'h09, 1'b0);

        // Clear beats load on the same edge; load ignores the enables.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0A); push(2, 8'h05, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07); push(2, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); push(2, 8'h07, 1'b0);

        // Down from zero: RCO independent of ENP, hold, then borrow wrap to 15.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); push(2, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00); push(2, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00); push(2, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); push(2, 8'h0F, 1'b0);

        // Cascade carry from the lower stage into the upper one.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00); push(3, 8'h0F, 1'b0); push(4, 8'h0F, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00); push(3, 8'h10, 1'b0); push(4, 8'h00, 1'b0);

        // Randomized traffic with sticky direction so wraps are reached.
        up_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(9) == 0) up_r = ~up_r;
            cycle($urandom_range(99) >= 2, $urandom_range(99) >= 6,
                  $urandom_range(99) < 85, $urandom_range(99) < 85,
                  up_r, 8'($urandom));
        end

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hc163_chain.md
HC163_CHAIN -- requirements
Module: hc163_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 4; counter width in bits, a multiple of 4, range 4..32; each 4-bit slice is one counter stage.
REQ-002 SHALL have parameter DECADE, default 0; 0 = binary stages (0..15), 1 = BCD stages (0..9).
REQ-003 SHALL have port p2, input, 1 bit; CLK, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port p1, input, 1 bit; ~CLR, synchronous active-low reset, sampled on the rising edge of p2.
REQ-005 SHALL have port p9, input, 1 bit; ~LOAD, synchronous active-low parallel load.
REQ-006 SHALL have port p7, input, 1 bit; ENP, count enable (parallel).
REQ-007 SHALL have port p10, input, 1 bit; ENT, count enable (trickle), which also gates the carry output.
REQ-008 SHALL have port p5, input, 1 bit; U/~D, count direction: 1 = up, 0 = down.
REQ-009 SHALL have port p_d, input, WIDTH bits; parallel load data.
REQ-010 SHALL have port p_q, output, WIDTH bits; counter state, registered.
REQ-011 SHALL have port p15, output, 1 bit; RCO, ripple carry/borrow out, combinational.

Function
REQ-012 SHALL evaluate per rising p2 edge in priority order: p1=0 clear > p9=0 load > (p7&p10)=1 count > hold.
REQ-013 SHALL set p_q to 0 on the edge when p1=0, regardless of p9, p7, p10, p5.
REQ-014 SHALL load p_q<=p_d on the edge when p1=1 and p9=0, regardless of p7 and p10; the load is not range-checked in DECADE mode.
REQ-015 SHALL advance by exactly one count per enabled edge, with 1-cycle latency: p_q shows the new value after the edge.
REQ-016 SHALL hold p_q unchanged when p7=0 or p10=0 and no clear or load is active.
REQ-017 SHALL, with DECADE=0, count modulo 2^WIDTH: up wraps max to 0, down wraps 0 to max.
REQ-018 SHALL, with DECADE=1, count each stage 0..9 with carry/borrow into the next stage: up wraps 99..9 to 0, down wraps 0 to 99..9.
REQ-019 SHALL, with DECADE=1 and an up count, step any stage holding 10..15 to 0 with no carry out of that stage.
REQ-020 SHALL, with DECADE=1 and a down count, step any stage holding 10..15 to 9 with no borrow out of that stage.
REQ-021 SHALL ripple a stage's carry into the next stage only when all lower stages are at terminal value for the current direction (up: 15 or 9; down: 0).
REQ-022 SHALL drive p15 = p10 & TC, where TC = (p_q == full-scale max) when p5=1 and TC = (p_q == 0) when p5=0; p15 is independent of p7.
REQ-023 SHALL take effect on the next edge when p5 changes between edges; there is no glitch filtering, and p15 follows p5 combinationally.
REQ-024 SHALL allow cascading: the p15 of one instance connects to p10 of the next, with a shared p2, p7 and p1.

Reset
REQ-025 SHALL provide reset only through synchronous p1=0; there is no asynchronous path, and the state before the first clear edge is undefined.
REQ-026 SHALL hold p_q=0 after a clear edge; p15 then equals p10 when p5=0 and 0 when p5=1.
REQ-027 SHALL abort any count or load on a clear asserted mid-sequence at that edge, with counting resuming from 0 on the first edge after p1 returns to 1.

Verification
REQ-028 SHALL pass: WIDTH=8, DECADE=0, p1=0 for 1 edge, then p7=p10=p5=1 for 256 edges -> p_q steps 0,1,...,255,0; p15=1 only while p_q=255.
REQ-029 SHALL pass: WIDTH=8, DECADE=1, load p_d=0x98 then count up 3 edges -> p_q = 0x99, 0x00, 0x01; p15=1 only at 0x99.
REQ-030 SHALL pass: WIDTH=8, DECADE=1, load 0x0C then count up 1 edge -> 0x00; load 0x0C then count down 1 edge -> 0x09.
REQ-031 SHALL pass: WIDTH=4, p_q=5, p9=0 and p1=0 on the same edge -> p_q=0; next edge p9=0, p_d=7, p7=0 -> p_q=7.
REQ-032 SHALL pass: WIDTH=4, p_q=0, p5=0, p10=1, p7=0 -> p15=1 and p_q holds; set p7=1 -> next edge p_q=15 and p15=0.
REQ-033 SHALL pass: two 4-bit instances cascaded with DECADE=0 and an up count from 0x0F -> one edge gives 0x10, with the upper stage advancing only on the edge where the lower stage's p15=1.
